// File: rtl/kms_event_decoder.sv
// Keyboard/mouse event decoder: turns level-toggle events into mouse position updates,
// a first-word-fall-through keycode FIFO and an OSD key strobe.
module kms_event_decoder #(
   parameter int FIFO_AW = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       kms_level,
   input  logic [1:0] kbd_mouse_type,
   input  logic [7:0] kbd_mouse_data,
   input  logic [2:0] mouse_buttons_in,
   output logic       key_valid,
   output logic [7:0] key_data,
   input  logic       key_ready,
   output logic       key_overflow,
   input  logic       ovf_clr,
   output logic       osd_key_stb,
   output logic [7:0] osd_key,
   output logic [7:0] mouse_x,
   output logic [7:0] mouse_y,
   output logic [2:0] mouse_btn
);
   localparam int DEPTH = 1 << FIFO_AW;

   logic               lvl_q;
   logic               armed;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;

   logic event_fire;
   logic push_req;
   logic pop;
   logic full;
   logic push;
   logic drop;

   // An edge only counts once the first post-reset sample has been taken.
   assign event_fire = armed && (kms_level != lvl_q);
   assign push_req   = event_fire && (kbd_mouse_type == 2'd2);
   assign key_valid  = (count != '0);
   assign key_data   = mem[rd_ptr];
   assign pop        = key_valid && key_ready;
   assign full       = (count == (FIFO_AW+1)'(DEPTH));
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push       = push_req && (!full || pop);
   assign drop       = push_req && full && !pop;

   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem[wr_ptr] <= kbd_mouse_data;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         lvl_q        <= 1'b0;
         armed        <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         key_overflow <= 1'b0;
         osd_key_stb  <= 1'b0;
         osd_key      <= 8'h00;
         mouse_x      <= 8'h00;
         mouse_y      <= 8'h00;
         mouse_btn    <= 3'b000;
      end else begin
         lvl_q       <= kms_level;
         armed       <= 1'b1;
         mouse_btn   <= mouse_buttons_in;
         osd_key_stb <= event_fire && (kbd_mouse_type == 2'd3);

         if (event_fire) begin
            unique case (kbd_mouse_type)
               2'd0:    mouse_x <= mouse_x + kbd_mouse_data;
               2'd1:    mouse_y <= mouse_y + kbd_mouse_data;
               2'd3:    osd_key <= kbd_mouse_data;
               default: ;
            endcase
         end

         if (push) begin
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: ;
         endcase

         // Setting wins over a simultaneous clear request.
         if (drop) begin
            key_overflow <= 1'b1;
         end else if (ovf_clr) begin
            key_overflow <= 1'b0;
         end
      end
   end
endmodule

// File: doc/kms_event_decoder.md
KMS_EVENT_DECODER -- requirements
Module: kms_event_decoder

Interface
REQ-001 SHALL have parameter: FIFO_AW, default 3, log2 of keycode FIFO depth (8 entries).
REQ-002 SHALL have port: clk_sys  in  1  system clock, same domain as HPS I/O block; all logic rising-edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: kms_level  in  1  toggles once per new keyboard/mouse event.
REQ-005 SHALL have port: kbd_mouse_type  in  2  0=mouse X delta, 1=mouse Y delta, 2=keycode, 3=OSD key.
REQ-006 SHALL have port: kbd_mouse_data  in  8  event payload.
REQ-007 SHALL have port: mouse_buttons_in  in  3  raw mouse button state.
REQ-008 SHALL have port: key_valid  out  1  FIFO non-empty.
REQ-009 SHALL have port: key_data  out  8  FIFO head (first-word fall-through).
REQ-010 SHALL have port: key_ready  in  1  consumer accepts head.
REQ-011 SHALL have port: key_overflow  out  1  sticky; keycode dropped.
REQ-012 SHALL have port: ovf_clr  in  1  clears key_overflow.
REQ-013 SHALL have port: osd_key_stb  out  1  one-cycle pulse, new OSD key.
REQ-014 SHALL have port: osd_key  out  8  last OSD keycode.
REQ-015 SHALL have port: mouse_x, mouse_y  out  8 each  wrap-around position counters.
REQ-016 SHALL have port: mouse_btn  out  3  registered button state.

Function
REQ-017 SHALL hold a registered copy lvl_q of kms_level and an armed flag; an event occurs at a rising edge where armed=1 and kms_level != lvl_q.
REQ-018 SHALL, on the first clock edge after reset deassertion, load lvl_q <= kms_level and set armed <= 1 without generating an event.
REQ-019 SHALL, on every edge while armed, load lvl_q <= kms_level.
REQ-020 SHALL act on the event in the same edge using kbd_mouse_type and kbd_mouse_data sampled at that edge; results visible after that edge (latency 1 cycle from toggle).
REQ-021 SHALL, on type 0, set mouse_x <= mouse_x + kbd_mouse_data (8-bit two's-complement add, modulo 256, no saturation); on type 1, apply the same to mouse_y.
REQ-022 SHALL, on type 2, push kbd_mouse_data into the FIFO if not full; if full with no simultaneous pop, drop the byte and set key_overflow.
REQ-023 SHALL, on type 3, load osd_key <= kbd_mouse_data and assert osd_key_stb for exactly one cycle; osd_key_stb SHALL be 0 at all other times.
REQ-024 SHALL implement the FIFO as 2^FIFO_AW x 8 with wrapping read/write pointers and a FIFO_AW+1-bit count; key_valid = (count != 0); key_data = entry at read pointer.
REQ-025 SHALL pop when key_valid && key_ready; key_ready while empty has no effect.
REQ-026 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers; when full this push is accepted and key_overflow is not set.
REQ-027 SHALL assert key_valid on the cycle after a push into an empty FIFO; a pushed byte is never popped in its push cycle.
REQ-028 SHALL clear key_overflow when ovf_clr=1; set takes priority over clear in the same cycle.
REQ-029 SHALL register mouse_btn <= mouse_buttons_in every cycle (1-cycle latency), independent of events.
REQ-030 SHALL process at most one event per cycle; a level toggle on consecutive cycles yields two events.

Reset
REQ-031 SHALL, while reset=1, asynchronously force: lvl_q=0, armed=0, FIFO pointers and count=0, key_valid=0, key_data contents don't-care, key_overflow=0, osd_key=0, osd_key_stb=0, mouse_x=0, mouse_y=0, mouse_btn=0.
REQ-032 SHALL discard all FIFO contents and any in-flight event when reset asserts mid-operation.

Verification
REQ-033 SHALL cover: release reset with kms_level=1 held -> no event, mouse_x=0, key_valid=0; then toggle to 0 with type 0, data 0x05 -> mouse_x=0x05 next cycle.
REQ-034 SHALL cover: mouse_x=0x02, type 0 event data 0xFD -> mouse_x=0xFF; further event data 0x03 -> mouse_x=0x02 (wrap both directions).
REQ-035 SHALL cover: 9 keycode events 0x10..0x18 with key_ready=0 -> count 8, key_overflow=1, pops return 0x10..0x17 in order, 0x18 lost.
REQ-036 SHALL cover: full FIFO, key_ready=1 and keycode event 0x40 same cycle -> count stays 8, key_overflow stays 0, 0x40 read last.
REQ-037 SHALL cover: type 3 event data 0x45 -> osd_key=0x45, osd_key_stb high exactly one cycle, FIFO unchanged.
REQ-038 SHALL cover: reset asserted with 3 keys queued and mouse_y=0x33 -> key_valid=0, mouse_y=0 immediately, no events until re-armed.
